// File: rtl/miter_sweep_checker.sv
// miter_sweep_checker: sweeps every address into a miter and tallies mismatch flags
module miter_sweep_checker #(
    parameter int ADDR_W  = 8,
    parameter int ERR_W   = 9,
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] in_A,
    input  logic              trigger,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
);
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
    localparam logic [3:0]        DRAIN_LAST = 4'(LATENCY == 0 ? 0 : LATENCY - 1);
    state_t            state, state_nx;
    logic [3:0]        drain_cnt;
    logic              launch, s_vld, hit;
    logic [ADDR_W-1:0] s_addr;
    assign busy   = (state == SWEEP) || (state == DRAIN);
    assign done   = state == DONE;
    assign pass   = done && (err_count == '0);
    assign launch = start && ((state == IDLE) || (state == DONE));
    assign hit    = s_vld && trigger && busy;
    // next-state: sweep to the top address, drain the tag pipeline, then hold results
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SWEEP : IDLE;
            SWEEP:   state_nx = (in_A == ADDR_MAX) ? ((LATENCY == 0) ? DONE : DRAIN) : SWEEP;
            DRAIN:   state_nx = (drain_cnt == DRAIN_LAST) ? DONE : DRAIN;
            default: state_nx = start ? SWEEP : DONE;
        endcase
    end
    // state register, drain timer and address sweep (holds the top address once reached)
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            in_A      <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
            in_A      <= launch ? '0 : ((state == SWEEP) && (in_A != ADDR_MAX)) ? in_A + 1'b1 : in_A;
        end
    end
    // tag pipeline: each swept address travels with a valid bit so late triggers land on the right address
    generate
        if (LATENCY == 0) begin : g_comb
            assign s_vld  = state == SWEEP;
            assign s_addr = in_A;
        end else begin : g_pipe
            logic [LATENCY-1:0] vq;
            logic [ADDR_W-1:0]  aq [LATENCY];
            // shift tags and addresses one slot per cycle; reset empties every slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    vq <= '0;
                    for (int i = 0; i < LATENCY; i++) aq[i] <= '0;
                end else begin
                    vq[0] <= state == SWEEP;
                    aq[0] <= in_A;
                    for (int i = 1; i < LATENCY; i++) begin
                        vq[i] <= vq[i-1];
                        aq[i] <= aq[i-1];
                    end
                end
            end
            assign s_vld  = vq[LATENCY-1];
            assign s_addr = aq[LATENCY-1];
        end
    endgenerate
    // results: cleared on reset or (re)start, saturating error count, first mismatch latched once
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (hit) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= s_addr;
            end
        end
    end
endmodule

// File: tb/tb_miter_sweep_checker.sv
// tb_miter_sweep_checker: directed vectors against three parameterisations of the sweep checker
module tb_miter_sweep_checker;
    typedef struct {
        int d;
        int tm;
        int cyc;
        int err;
        int ps;
        int fv;
        int fa;
    } vec_t;
    logic       clk = 0;
    logic       rst = 1;
    logic       st [3];
    logic       tg [3];
    logic       bz [3];
    logic       dn [3];
    logic       ps [3];
    logic       fv [3];
    logic [7:0] ia [3];
    logic [7:0] fa [3];
    logic [8:0] e0, e1;
    logic [3:0] e2;
    int         ec [3];
    int         tm [3];
    logic [2:0] d3 = '0;
    int         n_chk = 0;
    int         n_pass = 0;
    vec_t       v [6];
    always #5 clk = ~clk;
    miter_sweep_checker u0 (.clk(clk), .rst(rst), .start(st[0]), .in_A(ia[0]), .trigger(tg[0]),
        .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .err_count(e0), .first_err_valid(fv[0]), .first_err_addr(fa[0]));
    miter_sweep_checker #(.LATENCY(3)) u1 (.clk(clk), .rst(rst), .start(st[1]), .in_A(ia[1]), .trigger(tg[1]),
        .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .err_count(e1), .first_err_valid(fv[1]), .first_err_addr(fa[1]));
    miter_sweep_checker #(.ERR_W(4)) u2 (.clk(clk), .rst(rst), .start(st[2]), .in_A(ia[2]), .trigger(tg[2]),
        .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .err_count(e2), .first_err_valid(fv[2]), .first_err_addr(fa[2]));
    assign ec[0] = int'(e0);
    assign ec[1] = int'(e1);
    assign ec[2] = int'(e2);
    assign tg[0] = (tm[0] == 1) ? (ia[0] == 8'h10 || ia[0] == 8'hA5) : (tm[0] == 2);
    assign tg[1] = d3[2];
    assign tg[2] = (tm[2] == 1) ? (ia[2] == 8'h10 || ia[2] == 8'hA5) : (tm[2] == 2);
    always @(posedge clk) d3 <= {d3[1:0], ia[1] == 8'hFF};
    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask
    task automatic pulse_start(int d);
        @(negedge clk);
        st[d] = 1;
        @(negedge clk);
        st[d] = 0;
    endtask
    task automatic wait_done(int d, output int c);
        int k = 0;
        c = 0;
        while (!dn[d] && k < 2000) begin
            if (bz[d]) c++;
            k++;
            @(negedge clk);
        end
    endtask
    task automatic chk_idle(int d, string tag);
        chk({tag, " busy"}, int'(bz[d]), 0);
        chk({tag, " done"}, int'(dn[d]), 0);
        chk({tag, " pass"}, int'(ps[d]), 0);
        chk({tag, " err_count"}, ec[d], 0);
        chk({tag, " first_err_valid"}, int'(fv[d]), 0);
        chk({tag, " first_err_addr"}, int'(fa[d]), 0);
        chk({tag, " in_A"}, int'(ia[d]), 0);
    endtask
    task automatic run_vec(vec_t x, int i);
        int c;
        string s;
        s = $sformatf("vec%0d", i);
        tm[x.d] = x.tm;
        pulse_start(x.d);
        wait_done(x.d, c);
        chk({s, " busy_cycles"}, c, x.cyc);
        chk({s, " err_count"}, ec[x.d], x.err);
        chk({s, " pass"}, int'(ps[x.d]), x.ps);
        chk({s, " done"}, int'(dn[x.d]), 1);
        chk({s, " first_err_valid"}, int'(fv[x.d]), x.fv);
        chk({s, " first_err_addr"}, int'(fa[x.d]), x.fa);
        chk({s, " in_A_hold"}, int'(ia[x.d]), 255);
        chk({s, " busy_after"}, int'(bz[x.d]), 0);
    endtask
    initial begin
        int c, k, a;
        v[0] = '{d: 0, tm: 0, cyc: 256, err: 0,   ps: 1, fv: 0, fa: 0};
        v[1] = '{d: 0, tm: 1, cyc: 256, err: 2,   ps: 0, fv: 1, fa: 8'h10};
        v[2] = '{d: 1, tm: 0, cyc: 259, err: 1,   ps: 0, fv: 1, fa: 8'hFF};
        v[3] = '{d: 1, tm: 0, cyc: 259, err: 1,   ps: 0, fv: 1, fa: 8'hFF};
        v[4] = '{d: 2, tm: 2, cyc: 256, err: 15,  ps: 0, fv: 1, fa: 0};
        v[5] = '{d: 0, tm: 2, cyc: 256, err: 256, ps: 0, fv: 1, fa: 0};
        for (int i = 0; i < 3; i++) begin
            st[i] = 0;
            tm[i] = 0;
        end
        st[0] = 1;
        tm[0] = 2;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i, $sformatf("reset%0d", i));
        rst = 0;
        st[0] = 0;
        tm[0] = 0;
        @(negedge clk);
        chk("idle_no_start busy", int'(bz[0]), 0);
        for (int i = 0; i < 6; i++) run_vec(v[i], i);
        tm[0] = 1;
        pulse_start(0);
        k = 0;
        while (ia[0] != 8'h40 && k < 500) begin
            k++;
            @(negedge clk);
        end
        chk("midsweep reached_0x40", int'(ia[0]), 8'h40);
        chk("midsweep err_before_rst", ec[0], 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_idle(0, "midrst");
        @(negedge clk);
        chk_idle(0, "midrst_idle");
        run_vec(v[1], 1);
        tm[0] = 1;
        pulse_start(0);
        repeat (8'h2F) @(negedge clk);
        a = int'(ia[0]);
        st[0] = 1;
        @(negedge clk);
        st[0] = 0;
        chk("ignored_start in_A", int'(ia[0]), a + 1);
        chk("ignored_start busy", int'(bz[0]), 1);
        wait_done(0, c);
        chk("ignored_start err_count", ec[0], 2);
        chk("ignored_start first_err_addr", int'(fa[0]), 8'h10);
        tm[0] = 2;
        repeat (10) @(negedge clk);
        chk("done_hold done", int'(dn[0]), 1);
        chk("done_hold err_count", ec[0], 2);
        chk("done_hold pass", int'(ps[0]), 0);
        chk("done_hold first_err_valid", int'(fv[0]), 1);
        chk("done_hold first_err_addr", int'(fa[0]), 8'h10);
        st[0] = 1;
        @(negedge clk);
        st[0] = 0;
        chk("restart in_A", int'(ia[0]), 0);
        chk("restart err_count", ec[0], 0);
        chk("restart first_err_valid", int'(fv[0]), 0);
        chk("restart busy", int'(bz[0]), 1);
        chk("restart done", int'(dn[0]), 0);
        wait_done(0, c);
        chk("restart busy_cycles", c, 256);
        chk("restart err_count_final", ec[0], 256);
        chk("restart first_err_addr", int'(fa[0]), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
